// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 4-digit FND scan controller.
package fnd_pkg;

  localparam int unsigned DIGITS      = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam logic [3:0]  SEL_ALL_OFF = 4'hF;

  // Bit i set when digit i and every digit above it are zero; digit 0 is never masked.
  function automatic logic [3:0] lz_mask(input logic [15:0] shadow);
    logic [3:0] mask;
    logic       all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (shadow[4*i +: 4] == 4'd0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/fnd_prescaler.sv
// Free-running slot prescaler: counts 0..CLK_DIV-1 and flags the last clock of each slot.
module fnd_prescaler #(
  parameter int unsigned CLK_DIV = 100000,
  localparam int unsigned CW     = $clog2(CLK_DIV)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_tick,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick  = (r_count == LAST);
  assign o_count = r_count;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 4-digit BCD scan controller with dead time, leading-zero blanking
// and tear-free updates committed at frame boundaries.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_bcd,
  input  logic        i_load,
  input  logic        i_lzb,
  output logic [3:0]  o_digit_sel,
  output logic [3:0]  o_value,
  output logic        o_blank,
  output logic        o_frame,
  output logic        o_err
);

  localparam int unsigned   CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

  logic          w_tick;
  logic [CW-1:0] w_count;
  logic          w_boundary;
  logic          w_commit;
  logic [16:0]   w_next_word;
  logic          w_err_next;
  logic          w_dead;
  logic [3:0]    w_nib;
  logic [3:0]    w_lz;

  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic          r_lzb_shadow;
  logic [16:0]   r_staging;
  logic          r_pending;
  logic          r_frame;
  logic          r_err;

  fnd_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick),
    .o_count (w_count)
  );

  assign w_boundary = w_tick && (r_idx == 2'd3);
  assign w_commit   = w_boundary && (i_load || r_pending);
  // A load landing on the boundary clock bypasses staging and commits directly.
  assign w_next_word = i_load ? {i_lzb, i_bcd} : r_staging;

  always_comb begin
    w_err_next = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_next_word[4*d +: 4] > BCD_MAX) begin
        w_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx        <= 2'd0;
      r_shadow     <= '0;
      r_lzb_shadow <= 1'b0;
      r_staging    <= '0;
      r_pending    <= 1'b0;
      r_frame      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      if (i_load) begin
        r_staging <= {i_lzb, i_bcd};
      end
      if (w_boundary) begin
        r_pending <= 1'b0;
      end else if (i_load) begin
        r_pending <= 1'b1;
      end
      if (w_commit) begin
        r_lzb_shadow <= w_next_word[16];
        r_shadow     <= w_next_word[15:0];
        r_err        <= w_err_next;
      end
      r_frame <= w_commit;
    end
  end

  assign w_dead = (w_count < BLANK_CNT);
  assign w_nib  = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_lz   = lz_mask(r_shadow);

  assign o_digit_sel = w_dead ? SEL_ALL_OFF : ~(4'b0001 << r_idx);
  assign o_value     = w_nib;
  assign o_blank     = w_dead | (w_nib > BCD_MAX) | (r_lzb_shadow & w_lz[r_idx]);
  assign o_frame     = r_frame;
  assign o_err       = r_err;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: driver predicts commits, monitor checks every scan cycle.
module tb_fnd_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;
  localparam int FRAME   = 4 * CLK_DIV;

  typedef struct packed {
    logic        lzb;
    logic [15:0] bcd;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd = '0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [3:0]  digit_sel;
  logic [3:0]  value;
  logic        blank;
  logic        frame;
  logic        err;

  word_t q[$];
  word_t pend_w;
  bit    pend = 1'b0;
  int    k;
  int    n_cmp = 0;
  int    n_bad = 0;

  fnd_scan_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_bcd       (bcd),
    .i_load      (load),
    .i_lzb       (lzb),
    .o_digit_sel (digit_sel),
    .o_value     (value),
    .o_blank     (blank),
    .o_frame     (frame),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // Clocks elapsed since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, got, exp);
    end
  endtask

  function automatic bit word_err(input word_t w);
    for (int i = 0; i < 4; i++) begin
      if (((w.bcd >> (4 * i)) & 16'hF) > 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor: reference display model driven by elapsed time and the committed word.
  word_t cur = '0;
  bit    exp_err = 1'b0;
  int    m_idx, m_pre;
  int    m_nib;
  bit    m_dead, m_blank, m_frame;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur     = '0;
      exp_err = 1'b0;
      chk("rst_sel", digit_sel, 4'hF);
      chk("rst_value", value, 0);
      chk("rst_blank", blank, 1);
      chk("rst_frame", frame, 0);
      chk("rst_err", err, 0);
    end else begin
      m_frame = (k != 0) && (k % FRAME == 0) && (q.size() != 0);
      chk("frame", frame, m_frame);
      if (m_frame) begin
        cur     = q.pop_front();
        exp_err = word_err(cur);
      end
      m_pre   = k % CLK_DIV;
      m_idx   = (k / CLK_DIV) % 4;
      m_dead  = (m_pre < BLANK);
      m_nib   = (cur.bcd >> (4 * m_idx)) & 16'hF;
      m_blank = m_dead || (m_nib > 9) ||
                (cur.lzb && m_idx != 0 && (cur.bcd >> (4 * m_idx)) == 0);
      chk("err", err, exp_err);
      chk("digit_sel", digit_sel, m_dead ? 4'hF : (~(1 << m_idx)) & 4'hF);
      chk("value", value, m_nib);
      chk("blank", blank, m_blank);
    end
  end

  // Driver: one clock of stimulus, predicting which word the next boundary commits.
  task automatic cyc(input bit ld, input logic [15:0] b, input bit z);
    load = ld;
    bcd  = b;
    lzb  = z;
    if (k % FRAME == FRAME - 1) begin
      if (ld)        q.push_back({z, b});
      else if (pend) q.push_back(pend_w);
      pend = 1'b0;
    end else if (ld) begin
      pend   = 1'b1;
      pend_w = {z, b};
    end
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic idle_to(input int ph);
    while (k % FRAME != ph) cyc(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    load  = 1'b0;
    pend  = 1'b0;
    q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    int          n;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0)      n = 0;
      else if ($urandom_range(0, 9) == 0) n = $urandom_range(10, 15);
      else                                n = $urandom_range(1, 9);
      w = w | (16'(n) << (4 * i));
    end
    return w;
  endfunction

  initial begin
    do_reset(3);
    idle(4);
    cyc(1'b1, 16'h1234, 1'b0);
    idle(40);
    idle_to(2);
    cyc(1'b1, 16'h0070, 1'b1);
    idle(36);
    idle_to(2);
    cyc(1'b1, 16'h0000, 1'b1);
    idle(36);
    idle_to(2);
    cyc(1'b1, 16'h12A4, 1'b0);
    idle(36);
    idle_to(1);
    cyc(1'b1, 16'h9999, 1'b0);
    idle(3);
    cyc(1'b1, 16'h5555, 1'b0);
    idle(36);
    idle_to(FRAME - 1);
    cyc(1'b1, 16'h4321, 1'b0);
    idle(40);
    // Staged word still pending when reset hits at digit 2 must be lost.
    idle_to(9);
    cyc(1'b1, 16'h8888, 1'b1);
    idle(1);
    do_reset(2);
    idle(40);
    repeat (600) cyc($urandom_range(0, 7) == 0, rand_bcd(), 1'($urandom_range(0, 1)));
    idle(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
